seg_scan_controller: RTL and testbench

// Time-multiplexes the shared 8-digit seven-segment display (AN/CA..CG/DP) between N_DIGITS hex digits.

---
 rtl/seg_pkg.sv | 21 ++
 rtl/seg_scan_controller_hex.sv | 12 +
 rtl/seg_scan_controller.sv | 130 +++++++++++++
 tb/tb_seg_scan_controller.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Segment patterns are active-low {CA..CG}, seg[6]=CA.
package seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  localparam seg_t HEX_SEG [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06,
    7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60,
    7'h31, 7'h42, 7'h30, 7'h38
  };

  typedef enum logic {
    S_BLANK = 1'b0,
    S_DRIVE = 1'b1
  } scan_state_t;

endpackage

// File: rtl/seg_scan_controller_hex.sv
// Hex nibble to active-low seven-segment pattern.
// Purely combinational table lookup.
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] i_hex,
  output seg_t       o_seg
);

  assign o_seg = HEX_SEG[i_hex];

endmodule

// File: rtl/seg_scan_controller.sv
// Multiplexed seven-segment scanner with per-slot blanking.
// Digit data is shadowed and only refreshed at frame wrap.
module seg_scan_controller
  import seg_pkg::*;
#(
  parameter int N_DIGITS     = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                  CLK100MHZ,
  input  logic                  reset_n,
  input  logic [4*N_DIGITS-1:0] frame_data,
  input  logic [N_DIGITS-1:0]   frame_dp,
  input  logic [N_DIGITS-1:0]   digit_en,
  input  logic                  load_valid,
  output logic                  load_ready,
  output logic                  frame_start,
  output logic [N_DIGITS-1:0]   AN,
  output seg_t                  seg,
  output logic                  DP
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  if (REFRESH_DIV <= BLANK_CYCLES || BLANK_CYCLES < 1 ||
      N_DIGITS < 1 || N_DIGITS > 8) begin : g_bad_params
    $error("seg_scan_controller: illegal parameter set");
  end

  scan_state_t           r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [4*N_DIGITS-1:0] r_data_sh;
  logic [N_DIGITS-1:0]   r_dp_sh;
  logic [N_DIGITS-1:0]   r_en_sh;
  logic                  r_frame_start;
  logic [N_DIGITS-1:0]   r_an;
  seg_t                  r_seg;
  logic                  r_dp;

  logic                  w_slot_end;
  logic                  w_wrap;
  logic                  w_en;
  logic [3:0]            w_nib;
  seg_t                  w_seg;
  logic [3:0]            w_nibs [N_DIGITS];

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_nib
    assign w_nibs[g] = r_data_sh[4*g +: 4];
  end

  assign w_slot_end = (r_cnt == CNT_LAST);
  assign w_wrap     = (r_state == S_DRIVE) && w_slot_end &&
                      (r_idx == IDX_LAST);
  assign w_nib      = w_nibs[r_idx];
  assign w_en       = r_en_sh[r_idx];

  hex_to_seg u_hex (
    .i_hex (w_nib),
    .o_seg (w_seg)
  );

  // Slot prescaler, blank/drive FSM and digit index.
  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_BLANK;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      r_cnt <= w_slot_end ? '0 : r_cnt + 1'b1;
      unique case (r_state)
        S_BLANK: begin
          if (r_cnt == BLK_LAST)
            r_state <= S_DRIVE;
        end
        S_DRIVE: begin
          if (w_slot_end) begin
            r_state <= S_BLANK;
            r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
          end
        end
      endcase
    end
  end

  // Shadow copy of the frame, only replaced on the wrap handshake.
  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n) begin
      r_data_sh <= '0;
      r_dp_sh   <= '0;
      r_en_sh   <= '0;
    end else if (w_wrap && load_valid) begin
      r_data_sh <= frame_data;
      r_dp_sh   <= frame_dp;
      r_en_sh   <= digit_en;
    end
  end

  // Registered pin drive; blank everywhere except the active digit.
  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_start <= 1'b0;
      r_an          <= '1;
      r_seg         <= SEG_BLANK;
      r_dp          <= 1'b1;
    end else begin
      r_frame_start <= w_wrap;
      r_an          <= '1;
      r_seg         <= SEG_BLANK;
      r_dp          <= 1'b1;
      if (r_state == S_DRIVE) begin
        r_an[r_idx] <= ~w_en;
        r_seg       <= w_en ? w_seg : SEG_BLANK;
        r_dp        <= ~(r_dp_sh[r_idx] & w_en);
      end
    end
  end

  assign load_ready  = w_wrap;
  assign frame_start = r_frame_start;
  assign AN          = r_an;
  assign seg         = r_seg;
  assign DP          = r_dp;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Directed bench for seg_scan_controller with a 4-digit, 8-cycle slot.
// Checks blanking, capture handshake, masking, DP and mid-slot reset.
module tb_seg_scan_controller;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int BC = 2;
  localparam int FR = ND * RD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] frame_data = '0;
  logic [3:0]  frame_dp = '0;
  logic [3:0]  digit_en = '0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic        frame_start;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int p;
  int n_cmp = 0;
  int n_bad = 0;

  // Hand-derived patterns for frame_data 16'h1234: digit0=4 ... digit3=1.
  logic [6:0] exp_1234 [4] = '{7'h4C, 7'h06, 7'h12, 7'h4F};

  seg_scan_controller #(
    .N_DIGITS     (ND),
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC)
  ) dut (
    .CLK100MHZ   (clk),
    .reset_n     (rst_n),
    .frame_data  (frame_data),
    .frame_dp    (frame_dp),
    .digit_en    (digit_en),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .frame_start (frame_start),
    .AN          (an),
    .seg         (seg),
    .DP          (dp)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    p++;
    @(negedge clk);
  endtask

  // Output after edge p reflects the scan state after edge p-1.
  function automatic int slot_of(int pp);
    return ((pp - 1) % FR) / RD;
  endfunction

  function automatic bit drv_of(int pp);
    return ((pp - 1) % RD) >= BC;
  endfunction

  task automatic test_reset();
    #12;
    n_cmp++;
    if (an !== 4'hF) begin
      n_bad++;
      $display("FAIL rst_an got %h want f", an);
    end
    n_cmp++;
    if (seg !== 7'h7F) begin
      n_bad++;
      $display("FAIL rst_seg got %h want 7f", seg);
    end
    n_cmp++;
    if (dp !== 1'b1 || frame_start !== 1'b0 || load_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_ctl got dp=%b fs=%b lr=%b want 1 0 0",
               dp, frame_start, load_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    p = 0;
  endtask

  task automatic test_blank_frame();
    for (int k = 0; k < FR; k++) begin
      step();
      n_cmp++;
      if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin
        n_bad++;
        $display("FAIL blank p=%0d got an=%h seg=%h dp=%b want f 7f 1",
                 p, an, seg, dp);
      end
      n_cmp++;
      if (load_ready !== (p % FR == FR - 1)) begin
        n_bad++;
        $display("FAIL blank_lr p=%0d got %b want %b",
                 p, load_ready, (p % FR == FR - 1));
      end
      n_cmp++;
      if (frame_start !== (p % FR == 0)) begin
        n_bad++;
        $display("FAIL blank_fs p=%0d got %b want %b",
                 p, frame_start, (p % FR == 0));
      end
    end
  endtask

  task automatic test_capture();
    int s;
    bit d;
    int lows;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    load_valid = 1'b1;
    frame_data = 16'h1234;
    digit_en   = 4'hF;
    frame_dp   = 4'h0;
    for (int k = 0; k < FR; k++) begin
      step();
      n_cmp++;
      if (load_ready !== (p % FR == FR - 1)) begin
        n_bad++;
        $display("FAIL cap_lr p=%0d got %b want %b",
                 p, load_ready, (p % FR == FR - 1));
      end
    end
    load_valid = 1'b0;
    lows = 0;
    for (int k = 0; k < FR; k++) begin
      step();
      s = slot_of(p);
      d = drv_of(p);
      e_an  = d ? ~(4'b0001 << s) : 4'hF;
      e_seg = d ? exp_1234[s] : 7'h7F;
      if (an[0] === 1'b0) lows++;
      n_cmp++;
      if (an !== e_an || seg !== e_seg || dp !== 1'b1) begin
        n_bad++;
        $display("FAIL cap_disp p=%0d got an=%h seg=%h dp=%b want %h %h 1",
                 p, an, seg, dp, e_an, e_seg);
      end
    end
    n_cmp++;
    if (lows !== 6) begin
      n_bad++;
      $display("FAIL cap_an0_len got %0d want 6", lows);
    end
  endtask

  task automatic test_no_capture();
    int s;
    bit d;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    load_valid = 1'b1;
    frame_data = 16'hFFFF;
    for (int k = 0; k < FR; k++) begin
      step();
      load_valid = 1'b0;
      s = slot_of(p);
      d = drv_of(p);
      e_an  = d ? ~(4'b0001 << s) : 4'hF;
      e_seg = d ? exp_1234[s] : 7'h7F;
      n_cmp++;
      if (an !== e_an || seg !== e_seg) begin
        n_bad++;
        $display("FAIL nocap p=%0d got an=%h seg=%h want %h %h",
                 p, an, seg, e_an, e_seg);
      end
    end
  endtask

  task automatic test_enable_mask();
    int s;
    bit d;
    bit on;
    int odd_lows;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    load_valid = 1'b1;
    frame_data = 16'h1234;
    digit_en   = 4'b0101;
    frame_dp   = 4'b1010;
    for (int k = 0; k < FR; k++) step();
    load_valid = 1'b0;
    odd_lows = 0;
    for (int k = 0; k < FR; k++) begin
      step();
      s  = slot_of(p);
      d  = drv_of(p);
      on = d && (s == 0 || s == 2);
      e_an  = on ? ~(4'b0001 << s) : 4'hF;
      e_seg = on ? exp_1234[s] : 7'h7F;
      if (an[1] === 1'b0 || an[3] === 1'b0) odd_lows++;
      n_cmp++;
      if (an !== e_an || seg !== e_seg || dp !== 1'b1) begin
        n_bad++;
        $display("FAIL mask p=%0d got an=%h seg=%h dp=%b want %h %h 1",
                 p, an, seg, dp, e_an, e_seg);
      end
    end
    n_cmp++;
    if (odd_lows !== 0) begin
      n_bad++;
      $display("FAIL mask_off got %0d lows want 0", odd_lows);
    end
  endtask

  task automatic test_dp();
    int s;
    bit d;
    int dp_lows;
    logic e_dp;
    load_valid = 1'b1;
    frame_data = 16'h1234;
    digit_en   = 4'hF;
    frame_dp   = 4'b0100;
    for (int k = 0; k < FR; k++) step();
    load_valid = 1'b0;
    dp_lows = 0;
    for (int k = 0; k < FR; k++) begin
      step();
      s = slot_of(p);
      d = drv_of(p);
      e_dp = ~(d && s == 2);
      if (dp === 1'b0) dp_lows++;
      n_cmp++;
      if (dp !== e_dp) begin
        n_bad++;
        $display("FAIL dp p=%0d got %b want %b", p, dp, e_dp);
      end
    end
    n_cmp++;
    if (dp_lows !== 6) begin
      n_bad++;
      $display("FAIL dp_len got %0d want 6", dp_lows);
    end
  endtask

  task automatic test_reset_mid();
    int lr_cnt;
    for (int k = 0; k < 21; k++) step();
    n_cmp++;
    if (an !== 4'b1011) begin
      n_bad++;
      $display("FAIL mid_pre p=%0d got an=%h want b", p, an);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_async got an=%h seg=%h dp=%b want f 7f 1",
               an, seg, dp);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    p = 0;
    lr_cnt = 0;
    for (int k = 0; k < FR; k++) begin
      step();
      if (load_ready === 1'b1) lr_cnt++;
      n_cmp++;
      if (an !== 4'hF || seg !== 7'h7F) begin
        n_bad++;
        $display("FAIL mid_clr p=%0d got an=%h seg=%h want f 7f",
                 p, an, seg);
      end
      n_cmp++;
      if (frame_start !== (p == FR)) begin
        n_bad++;
        $display("FAIL mid_fs p=%0d got %b want %b",
                 p, frame_start, (p == FR));
      end
    end
    n_cmp++;
    if (lr_cnt !== 1) begin
      n_bad++;
      $display("FAIL mid_lr got %0d pulses want 1", lr_cnt);
    end
  endtask

  initial begin
    p = 0;
    test_reset();
    test_blank_frame();
    test_capture();
    test_no_capture();
    test_enable_mask();
    test_dp();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
